// File: rtl/id_ex_reg_pkg.sv
// Shared encodings and the ID/EX control bundle for the decode-to-execute pipeline register.
// Bubble control is all-zero so a reset register and an inserted bubble look identical.
package id_ex_reg_pkg;

    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUOP_W = 4;

    typedef enum logic [ALUOP_W-1:0] {
        AluAddu  = 4'h0,
        AluSubu  = 4'h1,
        AluRtype = 4'h2,
        AluAnd   = 4'h3,
        AluOr    = 4'h4,
        AluXor   = 4'h5,
        AluSlt   = 4'h6,
        AluSltu  = 4'h7,
        AluLui   = 4'h8
    } alu_op_e;

    typedef enum logic [1:0] {
        RegDstRt  = 2'b00,
        RegDstRd  = 2'b01,
        RegDstR31 = 2'b10,
        RegDstR26 = 2'b11
    } reg_dst_e;

    typedef enum logic [1:0] {
        WbAlu = 2'b00,
        WbMem = 2'b01,
        WbPc  = 2'b10,
        WbCp0 = 2'b11
    } mem_to_reg_e;

    typedef struct packed {
        logic        alu_src;
        alu_op_e     alu_op;
        reg_dst_e    reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        mem_to_reg_e mem_to_reg;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '{
        alu_src:    1'b0,
        alu_op:     AluAddu,
        reg_dst:    RegDstRt,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: WbAlu
    };

    // Selects the live control bundle or a bubble in one place.
    function automatic id_ex_ctrl_t ctrl_or_bubble(input logic live, input id_ex_ctrl_t ctrl);
        return live ? ctrl : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the ID instruction.
// A redirect kills the ID instruction, so it suppresses the front-end stall.
module hazard_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              mem_read_ex,
    input  logic              valid_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic              valid_id,
    input  logic              use_rs_id,
    input  logic [REG_AW-1:0] rs_id,
    input  logic              use_rt_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              flush,
    output logic              hazard,
    output logic              stall_if
);

    logic load_in_ex;
    logic rs_match;
    logic rt_match;

    // r0 is hardwired, so a load targeting it never creates a dependency.
    assign load_in_ex = mem_read_ex & valid_ex & (rt_ex != '0);
    assign rs_match   = use_rs_id & (rs_id == rt_ex);
    assign rt_match   = use_rt_id & (rt_id == rt_ex);

    assign hazard   = load_in_ex & valid_id & (rs_match | rt_match);
    assign stall_if = hazard & ~flush;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush bubbles and interrupt capture.
// Data fields always load from ID so forwarding compares stay deterministic during bubbles.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              intterupt,
    input  logic              validID,
    input  logic [DATA_W-1:0] pcID,
    input  logic [DATA_W-1:0] readdata1ID,
    input  logic [DATA_W-1:0] readdata2ID,
    input  logic [DATA_W-1:0] extenddataID,
    input  logic [REG_AW-1:0] rsaddrID,
    input  logic [REG_AW-1:0] rtaddrID,
    input  logic [REG_AW-1:0] rdaddrID,
    input  logic [4:0]        shamtID,
    input  logic [5:0]        FunctID,
    input  logic              UseRsID,
    input  logic              UseRtID,
    input  logic              ALUSrcID,
    input  logic [3:0]        ALUOpID,
    input  logic [1:0]        RegDstID,
    input  logic              RegWriteID,
    input  logic              MemReadID,
    input  logic              MemWriteID,
    input  logic [1:0]        MemtoRegID,
    input  logic              FlushID,
    output logic              validEX,
    output logic [DATA_W-1:0] pcEX,
    output logic [DATA_W-1:0] readdata1EX,
    output logic [DATA_W-1:0] readdata2EX,
    output logic [DATA_W-1:0] extenddataEX,
    output logic [REG_AW-1:0] rsaddrEX,
    output logic [REG_AW-1:0] rtaddrEX,
    output logic [REG_AW-1:0] rdaddrEX,
    output logic [4:0]        shamtEX,
    output logic [5:0]        FunctEX,
    output logic              ALUSrcEX,
    output logic [3:0]        ALUOpEX,
    output logic [1:0]        RegDstEX,
    output logic              RegWriteEX,
    output logic              MemReadEX,
    output logic              MemWriteEX,
    output logic [1:0]        MemtoRegEX,
    output logic              IrqTakenEX,
    output logic              StallIF
);

    id_ex_ctrl_t ctrl_id;
    id_ex_ctrl_t ctrl_ex;
    logic        hazard;
    logic        take;
    logic        load;
    logic        irq_pend;

    assign ctrl_id = '{
        alu_src:    ALUSrcID,
        alu_op:     alu_op_e'(ALUOpID),
        reg_dst:    reg_dst_e'(RegDstID),
        reg_write:  RegWriteID,
        mem_read:   MemReadID,
        mem_write:  MemWriteID,
        mem_to_reg: mem_to_reg_e'(MemtoRegID)
    };

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .mem_read_ex (ctrl_ex.mem_read),
        .valid_ex    (validEX),
        .rt_ex       (rtaddrEX),
        .valid_id    (validID),
        .use_rs_id   (UseRsID),
        .rs_id       (rsaddrID),
        .use_rt_id   (UseRtID),
        .rt_id       (rtaddrID),
        .flush       (FlushID),
        .hazard      (hazard),
        .stall_if    (StallIF)
    );

    // Priority flush > hazard > interrupt > invalid > load is folded into take and load.
    assign take = irq_pend & validID & ~hazard & ~FlushID;
    assign load = validID & ~FlushID & ~hazard & ~take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validEX      <= 1'b0;
            pcEX         <= '0;
            readdata1EX  <= '0;
            readdata2EX  <= '0;
            extenddataEX <= '0;
            rsaddrEX     <= '0;
            rtaddrEX     <= '0;
            rdaddrEX     <= '0;
            shamtEX      <= '0;
            FunctEX      <= '0;
            ctrl_ex      <= CTRL_BUBBLE;
            IrqTakenEX   <= 1'b0;
            irq_pend     <= 1'b0;
        end else begin
            validEX      <= load;
            pcEX         <= pcID;
            readdata1EX  <= readdata1ID;
            readdata2EX  <= readdata2ID;
            extenddataEX <= extenddataID;
            rsaddrEX     <= rsaddrID;
            rtaddrEX     <= rtaddrID;
            rdaddrEX     <= rdaddrID;
            shamtEX      <= shamtID;
            FunctEX      <= FunctID;
            ctrl_ex      <= ctrl_or_bubble(load, ctrl_id);
            IrqTakenEX   <= take;
            // A request still high on the take edge re-arms on the following edge.
            irq_pend     <= take ? 1'b0 : (irq_pend | intterupt);
        end
    end

    assign ALUSrcEX   = ctrl_ex.alu_src;
    assign ALUOpEX    = ctrl_ex.alu_op;
    assign RegDstEX   = ctrl_ex.reg_dst;
    assign RegWriteEX = ctrl_ex.reg_write;
    assign MemReadEX  = ctrl_ex.mem_read;
    assign MemWriteEX = ctrl_ex.mem_write;
    assign MemtoRegEX = ctrl_ex.mem_to_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a behavioural model pushes the expected EX state per cycle
// into a scoreboard queue; each scenario task pops and compares after the clock edge.
module tb_id_ex_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] ext;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic              alusrc;
        logic [3:0]        aluop;
        logic [1:0]        regdst;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [1:0]        memtoreg;
        logic              irq;
    } ex_t;

    logic              clk, reset, intterupt, validID;
    logic [DATA_W-1:0] pcID, readdata1ID, readdata2ID, extenddataID;
    logic [REG_AW-1:0] rsaddrID, rtaddrID, rdaddrID;
    logic [4:0]        shamtID;
    logic [5:0]        FunctID;
    logic              UseRsID, UseRtID, ALUSrcID;
    logic [3:0]        ALUOpID;
    logic [1:0]        RegDstID, MemtoRegID;
    logic              RegWriteID, MemReadID, MemWriteID, FlushID;
    logic              validEX;
    logic [DATA_W-1:0] pcEX, readdata1EX, readdata2EX, extenddataEX;
    logic [REG_AW-1:0] rsaddrEX, rtaddrEX, rdaddrEX;
    logic [4:0]        shamtEX;
    logic [5:0]        FunctEX;
    logic              ALUSrcEX;
    logic [3:0]        ALUOpEX;
    logic [1:0]        RegDstEX, MemtoRegEX;
    logic              RegWriteEX, MemReadEX, MemWriteEX, IrqTakenEX, StallIF;

    int   tests_run = 0;
    int   tests_failed = 0;
    ex_t  sb[$];
    ex_t  m_ex;
    logic m_pend;
    logic exp_stall, obs_stall;
    ex_t  exp_v, obs_v;

    id_ex_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset), .intterupt(intterupt), .validID(validID), .pcID(pcID),
        .readdata1ID(readdata1ID), .readdata2ID(readdata2ID), .extenddataID(extenddataID),
        .rsaddrID(rsaddrID), .rtaddrID(rtaddrID), .rdaddrID(rdaddrID), .shamtID(shamtID),
        .FunctID(FunctID), .UseRsID(UseRsID), .UseRtID(UseRtID), .ALUSrcID(ALUSrcID),
        .ALUOpID(ALUOpID), .RegDstID(RegDstID), .RegWriteID(RegWriteID),
        .MemReadID(MemReadID), .MemWriteID(MemWriteID), .MemtoRegID(MemtoRegID),
        .FlushID(FlushID), .validEX(validEX), .pcEX(pcEX), .readdata1EX(readdata1EX),
        .readdata2EX(readdata2EX), .extenddataEX(extenddataEX), .rsaddrEX(rsaddrEX),
        .rtaddrEX(rtaddrEX), .rdaddrEX(rdaddrEX), .shamtEX(shamtEX), .FunctEX(FunctEX),
        .ALUSrcEX(ALUSrcEX), .ALUOpEX(ALUOpEX), .RegDstEX(RegDstEX),
        .RegWriteEX(RegWriteEX), .MemReadEX(MemReadEX), .MemWriteEX(MemWriteEX),
        .MemtoRegEX(MemtoRegEX), .IrqTakenEX(IrqTakenEX), .StallIF(StallIF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ex_t observe();
        ex_t o;
        o = '{validEX, pcEX, readdata1EX, readdata2EX, extenddataEX, rsaddrEX, rtaddrEX,
              rdaddrEX, shamtEX, FunctEX, ALUSrcEX, ALUOpEX, RegDstEX, RegWriteEX,
              MemReadEX, MemWriteEX, MemtoRegEX, IrqTakenEX};
        return o;
    endfunction

    task automatic rand_id();
        validID = 1'b1; FlushID = 1'b0; intterupt = 1'b0; UseRsID = 1'b0; UseRtID = 1'b0;
        pcID = $urandom; readdata1ID = $urandom; readdata2ID = $urandom;
        extenddataID = $urandom; rsaddrID = 5'($urandom); rtaddrID = 5'($urandom);
        rdaddrID = 5'($urandom); shamtID = 5'($urandom); FunctID = 6'($urandom);
        ALUSrcID = 1'($urandom); ALUOpID = 4'($urandom); RegDstID = 2'($urandom);
        RegWriteID = 1'($urandom); MemReadID = 1'b0; MemWriteID = 1'($urandom);
        MemtoRegID = 2'($urandom);
    endtask

    // Model one cycle from the ID inputs, push the expected EX state, then clock.
    task automatic step();
        ex_t  nxt;
        logic haz, take;
        #1;
        haz = m_ex.memread && m_ex.valid && validID && (m_ex.rt != 5'd0) &&
              ((UseRsID && rsaddrID == m_ex.rt) || (UseRtID && rtaddrID == m_ex.rt));
        exp_stall = haz && !FlushID;
        obs_stall = StallIF;
        take = m_pend && validID && !haz && !FlushID;
        nxt = '0;
        nxt.pc = pcID; nxt.rd1 = readdata1ID; nxt.rd2 = readdata2ID; nxt.ext = extenddataID;
        nxt.rs = rsaddrID; nxt.rt = rtaddrID; nxt.rd = rdaddrID; nxt.shamt = shamtID;
        nxt.funct = FunctID;
        if (FlushID || haz) begin
            nxt.irq = 1'b0;
        end else if (take) begin
            nxt.irq = 1'b1;
        end else if (validID) begin
            nxt.valid = 1'b1; nxt.alusrc = ALUSrcID; nxt.aluop = ALUOpID;
            nxt.regdst = RegDstID; nxt.regwrite = RegWriteID; nxt.memread = MemReadID;
            nxt.memwrite = MemWriteID; nxt.memtoreg = MemtoRegID;
        end
        m_pend = take ? 1'b0 : (m_pend || intterupt);
        m_ex = nxt;
        sb.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ex = '0; m_pend = 1'b0; sb.delete();
    endtask

    task automatic test_reset();
        rand_id();
        reset = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        tests_run++;
        if (observe() !== ex_t'(0)) begin
            tests_failed++; $display("FAIL reset_outputs got %h want 0", observe());
        end
        tests_run++;
        if (StallIF !== 1'b0) begin
            tests_failed++; $display("FAIL reset_stall got %b want 0", StallIF);
        end
        reset = 1'b1;
        rand_id();
        RegWriteID = 1'b1;
        step();
        exp_v = sb.pop_front(); obs_v = observe();
        tests_run++;
        if (obs_v !== exp_v) begin
            tests_failed++; $display("FAIL reset_release got %h want %h", obs_v, exp_v);
        end
        tests_run++;
        if (validEX !== 1'b1) begin
            tests_failed++; $display("FAIL reset_release_valid got %b want 1", validEX);
        end
    endtask

    task automatic test_normal();
        rand_id();
        readdata1ID = 32'h1234; ALUOpID = 4'h2; RegWriteID = 1'b1;
        step();
        exp_v = sb.pop_front(); obs_v = observe();
        tests_run++;
        if (obs_v !== exp_v) begin
            tests_failed++; $display("FAIL normal_all got %h want %h", obs_v, exp_v);
        end
        tests_run++;
        if ({readdata1EX, ALUOpEX, RegWriteEX} !== {32'h1234, 4'h2, 1'b1}) begin
            tests_failed++;
            $display("FAIL normal_fields got %h/%h/%b want 1234/2/1",
                     readdata1EX, ALUOpEX, RegWriteEX);
        end
    endtask

    task automatic test_load_use();
        rand_id();
        MemReadID = 1'b1; rtaddrID = 5'd8;
        step();
        exp_v = sb.pop_front(); obs_v = observe();
        tests_run++;
        if (obs_v !== exp_v) begin
            tests_failed++; $display("FAIL lu_load got %h want %h", obs_v, exp_v);
        end
        rand_id();
        UseRsID = 1'b1; rsaddrID = 5'd8; RegWriteID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            exp_v = sb.pop_front(); obs_v = observe();
            tests_run++;
            if (obs_stall !== exp_stall || obs_stall !== (i == 0)) begin
                tests_failed++;
                $display("FAIL lu_stall_%0d got %b want %b", i, obs_stall, i == 0);
            end
            tests_run++;
            if (obs_v !== exp_v || validEX !== (i != 0) || RegWriteEX !== (i != 0)) begin
                tests_failed++; $display("FAIL lu_ex_%0d got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_zero_reg();
        rand_id();
        MemReadID = 1'b1; rtaddrID = 5'd0;
        step();
        void'(sb.pop_front());
        rand_id();
        UseRsID = 1'b1; rsaddrID = 5'd0;
        step();
        exp_v = sb.pop_front(); obs_v = observe();
        tests_run++;
        if (obs_stall !== 1'b0 || exp_stall !== 1'b0) begin
            tests_failed++; $display("FAIL zero_reg_stall got %b want 0", obs_stall);
        end
        rand_id();
        MemReadID = 1'b1; rtaddrID = 5'd9;
        step();
        void'(sb.pop_front());
        rand_id();
        UseRsID = 1'b1; rsaddrID = 5'd3; UseRtID = 1'b0; rtaddrID = 5'd9;
        step();
        exp_v = sb.pop_front(); obs_v = observe();
        tests_run++;
        if (obs_stall !== 1'b0) begin
            tests_failed++; $display("FAIL unused_rt_stall got %b want 0", obs_stall);
        end
        tests_run++;
        if (obs_v !== exp_v) begin
            tests_failed++; $display("FAIL unused_rt_ex got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_flush();
        rand_id();
        MemReadID = 1'b1; rtaddrID = 5'd8;
        step();
        void'(sb.pop_front());
        rand_id();
        UseRsID = 1'b1; rsaddrID = 5'd8; FlushID = 1'b1; RegWriteID = 1'b1;
        step();
        exp_v = sb.pop_front(); obs_v = observe();
        tests_run++;
        if (obs_stall !== 1'b0) begin
            tests_failed++; $display("FAIL flush_stall got %b want 0", obs_stall);
        end
        tests_run++;
        if (obs_v !== exp_v || validEX !== 1'b0) begin
            tests_failed++; $display("FAIL flush_bubble got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_irq();
        rand_id();
        pcID = 32'h0040_0010; RegWriteID = 1'b1; intterupt = 1'b1;
        step();
        void'(sb.pop_front());
        intterupt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            exp_v = sb.pop_front(); obs_v = observe();
            tests_run++;
            if (obs_v !== exp_v || IrqTakenEX !== (i == 0)) begin
                tests_failed++; $display("FAIL irq_take_%0d got %h want %h", i, obs_v, exp_v);
            end
        end
        tests_run++;
        if (pcEX !== 32'h0040_0010) begin
            tests_failed++; $display("FAIL irq_epc got %h want 00400010", pcEX);
        end
        // Deferred take: pulse, flushed cycle, empty slot, then the next valid instruction.
        intterupt = 1'b1;
        step();
        void'(sb.pop_front());
        intterupt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            FlushID = (i == 0);
            validID = (i != 1);
            pcID = 32'h0040_0100 + 32'(i * 4);
            step();
            exp_v = sb.pop_front(); obs_v = observe();
            tests_run++;
            if (obs_v !== exp_v || IrqTakenEX !== (i == 2)) begin
                tests_failed++; $display("FAIL irq_defer_%0d got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            rand_id();
            validID = ($urandom_range(0, 7) != 0);
            FlushID = ($urandom_range(0, 9) == 0);
            intterupt = ($urandom_range(0, 19) == 0);
            MemReadID = 1'($urandom);
            UseRsID = 1'($urandom); UseRtID = 1'($urandom);
            rsaddrID = 5'($urandom_range(0, 3)); rtaddrID = 5'($urandom_range(0, 3));
            step();
            exp_v = sb.pop_front(); obs_v = observe();
            tests_run++;
            if (obs_stall !== exp_stall || obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_%0d got %b/%h want %b/%h", i, obs_stall, obs_v,
                         exp_stall, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        rand_id();
        MemReadID = 1'b1; rtaddrID = 5'd12;
        step();
        void'(sb.pop_front());
        rand_id();
        UseRtID = 1'b1; rtaddrID = 5'd12;
        #1;
        tests_run++;
        if (StallIF !== 1'b1) begin
            tests_failed++; $display("FAIL midstall_pre got %b want 1", StallIF);
        end
        reset = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (StallIF !== 1'b0 || observe() !== ex_t'(0)) begin
            tests_failed++; $display("FAIL midstall_reset got %b/%h want 0/0", StallIF, observe());
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        rand_id();
        model_reset();
        test_reset();
        test_normal();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_irq();
        test_back_to_back();
        test_reset_mid_stall();
        test_normal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
